// File: rtl/bf_bus_pkg.sv
// Shared definitions for the BF chip 8-bit serial bus: op codes, phase codes and widths.
// Used by both the chip-side bus FSM and the board-side responder.
package bf_bus_pkg;

    localparam int BF_ADDR_WIDTH = 15;
    localparam int BF_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        OP_NONE = 3'b000,
        OP_PRD  = 3'b010,
        OP_DRD  = 3'b100,
        OP_DWR  = 3'b101,
        OP_IN   = 3'b110,
        OP_OUT  = 3'b111
    } bf_op_e;

    typedef enum logic [2:0] {
        PH_IDLE = 3'd0,
        PH_OP   = 3'd1,
        PH_AHI  = 3'd2,
        PH_ALO  = 3'd3,
        PH_DATA = 3'd4
    } bf_phase_e;

    function automatic logic is_mem_op(input logic [2:0] op);
        return (op == OP_PRD) || (op == OP_DRD) || (op == OP_DWR);
    endfunction

endpackage

// File: rtl/bf_bus_responder.sv
// Board-side end of the BF chip serial bus: deframes op/addr/wdata, executes the access on
// the memory port or byte streams, and returns the result with a one-cycle op_done.
module bf_bus_responder
    import bf_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = BF_ADDR_WIDTH,
    parameter int DATA_WIDTH = BF_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  run,
    input  logic [DATA_WIDTH-1:0] chip_bus,
    input  logic [2:0]            chip_phase,
    input  logic                  chip_halted,
    output logic                  chip_enable,
    output logic                  op_done,
    output logic [DATA_WIDTH-1:0] bus_in,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  mem_space,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  proto_err,
    output logic                  run_done
);

    typedef enum logic [2:0] {
        R_WAIT, R_AHI, R_ALO, R_WDAT, R_MEM, R_IN, R_OUT, R_DONE
    } state_e;

    state_e                r_state;
    logic [2:0]            r_op;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_discard;
    logic                  r_chip_enable;
    logic                  r_op_done;
    logic [DATA_WIDTH-1:0] r_bus_in;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic                  r_mem_space;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_in_ready;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_valid;
    logic                  r_proto_err;
    logic                  r_run_done;

    state_e                w_state_next;
    logic [DATA_WIDTH-1:0] w_rdata_next;
    logic [DATA_WIDTH-1:0] w_wdata_next;
    logic                  w_discard_next;
    logic                  w_abort;
    logic                  w_proto_err;
    logic                  w_cap_op;
    logic                  w_cap_ahi;
    logic                  w_cap_alo;
    logic                  w_cap_wdat;
    logic                  w_mismatch;

    // A chip-side phase is only meaningful at edges where the chip itself advances.
    assign w_mismatch   = r_chip_enable && (chip_phase != PH_DATA);
    assign w_wdata_next = w_cap_wdat ? chip_bus : r_wdata;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_next   = r_state;
        w_rdata_next   = r_rdata;
        w_discard_next = r_discard;
        w_abort        = 1'b0;
        w_proto_err    = 1'b0;
        w_cap_op       = 1'b0;
        w_cap_ahi      = 1'b0;
        w_cap_alo      = 1'b0;
        w_cap_wdat     = 1'b0;

        case (r_state)
            R_WAIT: begin
                if (r_chip_enable && chip_phase == PH_OP) begin
                    w_cap_op     = 1'b1;
                    w_state_next = R_AHI;
                end
            end
            R_AHI: begin
                if (r_chip_enable) begin
                    if (chip_phase == PH_AHI) begin
                        w_cap_ahi    = 1'b1;
                        w_state_next = R_ALO;
                    end else begin
                        w_abort = 1'b1;
                    end
                end
            end
            R_ALO: begin
                if (r_chip_enable) begin
                    if (chip_phase == PH_ALO) begin
                        w_cap_alo    = 1'b1;
                        w_state_next = R_WDAT;
                    end else begin
                        w_abort = 1'b1;
                    end
                end
            end
            R_WDAT: begin
                if (r_chip_enable) begin
                    if (chip_phase == PH_DATA) begin
                        w_cap_wdat = 1'b1;
                        if (is_mem_op(r_op)) begin
                            w_state_next = R_MEM;
                        end else if (r_op == OP_IN) begin
                            w_state_next = R_IN;
                        end else if (r_op == OP_OUT) begin
                            w_state_next = R_OUT;
                        end else begin
                            w_rdata_next = '0;
                            w_state_next = R_DONE;
                        end
                    end else begin
                        w_abort = 1'b1;
                    end
                end
            end
            R_MEM: begin
                // An outstanding memory request is never withdrawn; a broken frame only
                // discards its result once the ack arrives.
                if (w_mismatch) begin
                    w_proto_err    = 1'b1;
                    w_discard_next = 1'b1;
                end
                if (mem_ack) begin
                    if (!w_discard_next) begin
                        w_rdata_next = r_mem_we ? r_wdata : mem_rdata;
                    end
                    w_state_next   = w_discard_next ? R_WAIT : R_DONE;
                    w_discard_next = 1'b0;
                end
            end
            R_IN: begin
                if (in_valid && r_in_ready) begin
                    w_proto_err  = w_mismatch;
                    w_rdata_next = in_data;
                    w_state_next = w_mismatch ? R_WAIT : R_DONE;
                end else if (w_mismatch) begin
                    w_abort = 1'b1;
                end
            end
            R_OUT: begin
                if (w_mismatch) begin
                    w_proto_err    = 1'b1;
                    w_discard_next = 1'b1;
                end
                if (out_ready) begin
                    if (!w_discard_next) begin
                        w_rdata_next = r_wdata;
                    end
                    w_state_next   = w_discard_next ? R_WAIT : R_DONE;
                    w_discard_next = 1'b0;
                end
            end
            R_DONE: begin
                if (r_chip_enable) begin
                    w_state_next = R_WAIT;
                end
            end
        endcase

        if (w_abort) begin
            w_proto_err = 1'b1;
            if (chip_phase == PH_OP) begin
                w_cap_op     = 1'b1;
                w_state_next = R_AHI;
            end else begin
                w_state_next = R_WAIT;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= R_WAIT;
            r_op          <= '0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_rdata       <= '0;
            r_discard     <= 1'b0;
            r_chip_enable <= 1'b0;
            r_op_done     <= 1'b0;
            r_bus_in      <= '0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_space   <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_in_ready    <= 1'b0;
            r_out_data    <= '0;
            r_out_valid   <= 1'b0;
            r_proto_err   <= 1'b0;
            r_run_done    <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            r_chip_enable <= run;
            if (r_chip_enable) begin
                r_run_done <= chip_halted;
            end

            r_state   <= w_state_next;
            r_rdata   <= w_rdata_next;
            r_discard <= w_discard_next;
            r_wdata   <= w_wdata_next;
            if (w_proto_err) begin
                r_proto_err <= 1'b1;
            end
            if (w_cap_op) begin
                r_op <= chip_bus[2:0];
            end
            if (w_cap_ahi) begin
                r_addr[ADDR_WIDTH-1:8] <= chip_bus[ADDR_WIDTH-9:0];
            end
            if (w_cap_alo) begin
                r_addr[7:0] <= chip_bus[7:0];
            end

            // Outputs are registered images of the next state, quiet outside their own state.
            r_op_done   <= (w_state_next == R_DONE);
            r_bus_in    <= (w_state_next == R_DONE) ? w_rdata_next : '0;
            r_mem_req   <= (w_state_next == R_MEM);
            r_mem_we    <= (w_state_next == R_MEM) && (r_op == OP_DWR);
            r_mem_space <= (w_state_next == R_MEM) && (r_op != OP_PRD);
            r_mem_addr  <= (w_state_next == R_MEM) ? r_addr : '0;
            r_mem_wdata <= (w_state_next == R_MEM) ? w_wdata_next : '0;
            r_in_ready  <= (w_state_next == R_IN);
            r_out_valid <= (w_state_next == R_OUT);
            r_out_data  <= (w_state_next == R_OUT) ? w_wdata_next : '0;
        end
    end

    assign chip_enable = r_chip_enable;
    assign op_done     = r_op_done;
    assign bus_in      = r_bus_in;
    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_space   = r_mem_space;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign in_ready    = r_in_ready;
    assign out_data    = r_out_data;
    assign out_valid   = r_out_valid;
    assign proto_err   = r_proto_err;
    assign run_done    = r_run_done;

endmodule
